// File: rtl/imm_extend_pipe.sv
// Immediate extender behind a two-entry skid buffer.
// Results are extended at accept time and leave in accept order; in_ready is registered.
module imm_extend_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_imm,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] xfer_cnt
);

    generate
        if (OUT_WIDTH < IN_WIDTH + 2) begin : g_bad_width
            $error("imm_extend_pipe: OUT_WIDTH must be at least IN_WIDTH+2");
        end
    endgenerate

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e                 state_q, state_d;
    logic [OUT_WIDTH-1:0]   main_q, main_d;
    logic [OUT_WIDTH-1:0]   skid_q, skid_d;
    logic                   in_ready_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [OUT_WIDTH-1:0]   ext;
    logic [OUT_WIDTH-1:0]   sext;
    logic                   accept;
    logic                   emit;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign xfer_cnt  = cnt_q;
    assign accept    = in_valid && in_ready_q;
    assign emit      = out_valid && out_ready;

    always_comb begin
        sext = {{(OUT_WIDTH-IN_WIDTH){in_imm[IN_WIDTH-1]}}, in_imm};
        ext  = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, in_imm};
        case (in_mode)
            2'b00:   ext = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, in_imm};
            2'b01:   ext = sext;
            2'b10:   ext = {in_imm, {(OUT_WIDTH-IN_WIDTH){1'b0}}};
            2'b11:   ext = {sext[OUT_WIDTH-3:0], 2'b00};
            default: ext = {{(OUT_WIDTH-IN_WIDTH){1'b0}}, in_imm};
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = ext;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && !emit) begin
                    skid_d  = ext;
                    state_d = TWO;
                end else if (accept && emit) begin
                    main_d  = ext;
                end else if (emit) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only the drain path exists
                if (emit) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != TWO);
            if (emit) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and randomized checks for imm_extend_pipe against a scoreboard model.
module tb_imm_extend_pipe;
    localparam int IW = 16;
    localparam int OW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [IW-1:0] in_imm = '0;
    logic [1:0] in_mode = '0;
    logic in_ready, out_valid, in_ready4, out_valid4;
    logic [OW-1:0] out_data, out_data4;
    logic [15:0] xfer_cnt;
    logic [3:0] xfer_cnt4;

    int checks = 0;
    int errors = 0;
    int emitted = 0;
    logic [OW-1:0] q[$];

    always #5 clk = ~clk;

    imm_extend_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .xfer_cnt(xfer_cnt));

    imm_extend_pipe #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .xfer_cnt(xfer_cnt4));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Arithmetic reference for the four extension modes
    function automatic logic [OW-1:0] model(input logic [IW-1:0] imm, input logic [1:0] m);
        logic [63:0] v;
        logic [63:0] r;
        v = 64'(imm);
        if (imm[IW-1]) v = v - 64'h10000;
        case (m)
            2'd0:    r = 64'(imm);
            2'd1:    r = v;
            2'd2:    r = 64'(imm) * 64'h10000;
            default: r = v * 64'd4;
        endcase
        return r[OW-1:0];
    endfunction

    task automatic cycle();
        logic acc, emt, hold;
        logic [OW-1:0] d;
        acc  = in_valid && in_ready;
        emt  = out_valid && out_ready;
        hold = out_valid && !out_ready;
        d    = out_data;
        if (emt) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL spurious_emit: got %0h expected nothing", out_data);
            end else begin
                if (out_data !== q[0]) begin
                    errors++;
                    $display("FAIL order: got %0h expected %0h", out_data, q[0]);
                end
                void'(q.pop_front());
                emitted++;
            end
        end
        if (acc) q.push_back(model(in_imm, in_mode));
        @(posedge clk); #1;
        if (hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, d);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        q.delete(); emitted = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [IW-1:0] imm;
        logic [1:0]    mode;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t tv[11];

    initial begin
        int acc_n, budget;
        logic acc;
        tv[0]  = '{16'h8001, 2'd0, 32'h00008001};
        tv[1]  = '{16'h8001, 2'd1, 32'hFFFF8001};
        tv[2]  = '{16'h8001, 2'd2, 32'h80010000};
        tv[3]  = '{16'h8001, 2'd3, 32'hFFFE0004};
        tv[4]  = '{16'h7FFF, 2'd1, 32'h00007FFF};
        tv[5]  = '{16'h7FFF, 2'd2, 32'h7FFF0000};
        tv[6]  = '{16'h7FFF, 2'd3, 32'h0001FFFC};
        tv[7]  = '{16'hFFFF, 2'd0, 32'h0000FFFF};
        tv[8]  = '{16'hFFFF, 2'd1, 32'hFFFFFFFF};
        tv[9]  = '{16'hFFFF, 2'd3, 32'hFFFFFFFC};
        tv[10] = '{16'h0000, 2'd3, 32'h00000000};

        // Reset state and in_ready rising on the first edge after release
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("ready_before_edge", in_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_edge", in_ready, 1);

        // Table: one-cycle latency for each mode
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; in_imm = tv[i].imm; in_mode = tv[i].mode;
            chk("tv_ready", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("tv_valid", out_valid, 1);
            chk($sformatf("tv_data[%0d]", i), out_data, tv[i].exp);
            @(posedge clk); #1;
            chk("tv_drained", out_valid, 0);
        end
        chk("tv_cnt", xfer_cnt, 11);

        // Backpressure: three offers, two accepted, first result held
        do_reset();
        in_valid = 1'b1; in_imm = 16'h1234; in_mode = 2'd0;
        cycle();
        chk("bp_data1", out_data, 32'h00001234);
        chk("bp_ready1", in_ready, 1);
        in_imm = 16'h8000; in_mode = 2'd1;
        cycle();
        chk("bp_ready2", in_ready, 0);
        in_imm = 16'h0ABC; in_mode = 2'd2;
        cycle();
        chk("bp_ready3", in_ready, 0);
        chk("bp_data3", out_data, 32'h00001234);
        chk("bp_accepted", q.size(), 2);

        // Drain from TWO with continuous input
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            acc = in_valid && in_ready;
            cycle();
            chk("refill_valid", out_valid, 1);
            if (acc) begin in_imm = in_imm + 16'h1111; in_mode = in_mode + 2'd1; end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("refill_empty", q.size(), 0);
        chk("refill_cnt", xfer_cnt, 16'(emitted));

        // Reset while holding two entries
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_imm = 16'h0011; in_mode = 2'd0;
        cycle();
        in_imm = 16'h0022;
        cycle();
        out_ready = 1'b0; in_imm = 16'h0033;
        cycle();
        in_valid = 1'b0;
        chk("two_ready", in_ready, 0);
        chk("two_cnt", xfer_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_cnt", xfer_cnt, 0);
        chk("async_ready", in_ready, 0);
        chk("async_data", out_data, 0);
        q.delete(); emitted = 0;
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("no_stale", out_valid, 0);
        end

        // Counter wrap on the narrow instance
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            in_imm = 16'(k * 3); in_mode = 2'(k);
            cycle();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("wrap_emitted", emitted, 17);
        chk("wrap_cnt4", xfer_cnt4, 1);
        chk("wrap_cnt16", xfer_cnt, 17);

        // Random backpressure stream
        do_reset();
        acc_n = 0; budget = 0;
        while (acc_n < 1000 && budget < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1) == 1;
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom);
            if (in_valid && in_ready) acc_n++;
            cycle();
            budget++;
        end
        chk("rand_accepts", acc_n, 1000);
        in_valid = 1'b0; out_ready = 1'b1;
        budget = 0;
        while (q.size() != 0 && budget < 10) begin cycle(); budget++; end
        cycle();
        chk("rand_empty", q.size(), 0);
        chk("rand_emitted", emitted, 1000);
        chk("rand_cnt", xfer_cnt, 1000);
        chk("rand_idle", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_WIDTH, default 16, is the width of the immediate field.
REQ-002 Parameter OUT_WIDTH, default 32, is the width of the datapath word; OUT_WIDTH >= IN_WIDTH+2 SHALL be enforced at elaboration.
REQ-003 Parameter CNT_WIDTH, default 16, is the width of the completed-transfer counter.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port clk, input, 1, rising-edge clock.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port in_valid, input, 1, upstream request carries a valid immediate.
REQ-008 Port in_ready, output, 1, block accepts a request this cycle.
REQ-009 Port in_imm, input, IN_WIDTH, raw immediate field.
REQ-010 Port in_mode, input, 2, extension mode: 00 zero, 01 sign, 10 upper, 11 branch.
REQ-011 Port out_valid, output, 1, out_data holds a result.
REQ-012 Port out_ready, input, 1, downstream consumes the result this cycle.
REQ-013 Port out_data, output, OUT_WIDTH, extended word.
REQ-014 Port xfer_cnt, output, CNT_WIDTH, count of completed output transfers.

Function
REQ-015 Accept SHALL occur when in_valid && in_ready at a rising edge; emit SHALL occur when out_valid && out_ready.
REQ-016 Mode 00 SHALL produce {zeros, in_imm}.
REQ-017 Mode 01 SHALL replicate in_imm[IN_WIDTH-1] into bits OUT_WIDTH-1..IN_WIDTH.
REQ-018 Mode 10 SHALL produce in_imm in bits OUT_WIDTH-1..OUT_WIDTH-IN_WIDTH and zeros below.
REQ-019 Mode 11 SHALL produce the sign-extended value shifted left by 2, with bits 1..0 zero, truncated to OUT_WIDTH.
REQ-020 Extension SHALL be computed at accept time from in_imm and in_mode sampled together; later input changes SHALL NOT alter a stored result.
REQ-021 Storage SHALL be a two-entry skid buffer: main register driving out_data, plus one skid register.
REQ-022 States: EMPTY (none valid), ONE (main valid), TWO (main and skid valid).
REQ-023 in_ready SHALL be a registered signal equal to (state != TWO); it SHALL NOT depend combinationally on out_ready.
REQ-024 out_valid SHALL equal (state != EMPTY); out_data SHALL always come from the main register.
REQ-025 EMPTY: an accept loads main and moves to ONE.
REQ-026 ONE: accept without emit loads skid and moves to TWO; emit without accept moves to EMPTY; accept and emit together loads main and stays in ONE.
REQ-027 TWO: emit moves the skid into main and goes to ONE; no accept is possible.
REQ-028 Latency from accept to out_valid SHALL be exactly 1 cycle when the block is EMPTY.
REQ-029 Sustained throughput SHALL be one transfer per cycle when out_ready is held high.
REQ-030 Results SHALL leave in accept order, with none dropped or duplicated.
REQ-031 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-032 xfer_cnt SHALL increment by 1 on each emit and wrap from 2^CNT_WIDTH-1 to 0.

Reset
REQ-033 rst_n low SHALL immediately force: state EMPTY, out_valid 0, in_ready 0, out_data 0, skid data 0, xfer_cnt 0.
REQ-034 in_ready SHALL rise on the first rising clk edge after rst_n deasserts.
REQ-035 Reset asserted mid-operation SHALL discard all buffered results; none SHALL be emitted after release.

Verification
REQ-036 Run with defaults, out_ready=1, and send 0x8001 in each mode 00/01/10/11. Required outputs: 0x00008001, 0xFFFF8001, 0x80010000, 0xFFFE0004, each 1 cycle after its accept.
REQ-037 Hold out_ready=0 and offer 3 back-to-back requests. Required: 2 accepted, in_ready low from the cycle after the 2nd accept, out_data stable on the 1st result.
REQ-038 From the TWO state, raise out_ready=1 with continuous in_valid. Required: results emitted in order, one per cycle after refill, and xfer_cnt matches the number emitted.
REQ-039 Toggle out_ready randomly for 1000 requests with random modes. Required: the output stream equals a reference-model stream in order, with no loss or duplication.
REQ-040 Assert rst_n low while in TWO. Required: out_valid drops asynchronously, xfer_cnt reads 0, and no stale result appears after release.
REQ-041 Use CNT_WIDTH=4 and emit 17 results. Required: xfer_cnt reads 1.
